// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one 4-bit ALU between NUM_REQ requesters, with a
// one-entry registered response stage that supports backpressure.
module alu_rr_arbiter #(
  parameter int unsigned  NUM_REQ = 4,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [4*NUM_REQ-1:0] req_a,
  input  logic [4*NUM_REQ-1:0] req_b,
  input  logic [3*NUM_REQ-1:0] req_op,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  output logic [2:0]           alu_op,
  input  logic [3:0]           alu_result,
  input  logic                 alu_carry,
  input  logic                 alu_zero,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [3:0]           rsp_result,
  output logic                 rsp_carry,
  output logic                 rsp_zero
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [3:0]      rsp_result_q, rsp_result_d;
  logic            rsp_carry_q, rsp_carry_d;
  logic            rsp_zero_q, rsp_zero_d;

  logic            can_issue;
  logic            gnt_found;
  logic [ID_W-1:0] gnt_idx;
  logic [ID_W-1:0] cand;

  // The slot is free if empty, or if the held response leaves on this edge.
  assign can_issue = (state_q == StEmpty) || rsp_ready;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    if (can_issue) begin
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
        cand = ID_W'((32'(ptr_q) + off) % NUM_REQ);
        if (!gnt_found && req_valid[cand]) begin
          gnt_found = 1'b1;
          gnt_idx   = cand;
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    alu_a     = '0;
    alu_b     = '0;
    alu_op    = '0;
    if (gnt_found) begin
      req_ready[gnt_idx] = 1'b1;
      alu_a              = req_a[4*32'(gnt_idx) +: 4];
      alu_b              = req_b[4*32'(gnt_idx) +: 4];
      alu_op             = req_op[3*32'(gnt_idx) +: 3];
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_zero_d   = rsp_zero_q;
    if (gnt_found) begin
      state_d      = StFull;
      ptr_d        = ID_W'((32'(gnt_idx) + 32'd1) % NUM_REQ);
      rsp_id_d     = gnt_idx;
      rsp_result_d = alu_result;
      rsp_zero_d   = alu_zero;
      // Carry is only meaningful for add/sub; the ALU leaves it undefined otherwise.
      rsp_carry_d  = (alu_op[2:1] == 2'b00) ? alu_carry : 1'b0;
    end else if ((state_q == StFull) && rsp_ready) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StEmpty;
      ptr_q        <= '0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_zero_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_zero_q   <= rsp_zero_d;
    end
  end

  assign rsp_valid  = (state_q == StFull);
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_carry  = rsp_carry_q;
  assign rsp_zero   = rsp_zero_q;

endmodule
